// File: rtl/hdmi_pkg.sv
// Shared types and timing constants for the HDMI period scheduler.
// Covers period codes, scheduler states, encoder control bundle and launch margins.
package hdmi_pkg;

    localparam int unsigned PREAMBLE_LEN    = 8;
    localparam int unsigned GUARD_LEN       = 2;
    localparam int unsigned PACKET_LEN      = 32;
    localparam int unsigned ISLAND_MARGIN   = 58;
    localparam int unsigned CONTINUE_MARGIN = 48;
    localparam int unsigned VIDEO_TRIGGER   = 10;

    localparam int unsigned BLANK_W         = 12;
    localparam int unsigned IDX_W           = $clog2(PACKET_LEN);
    localparam int unsigned TIMER_W         = 3;
    localparam int unsigned CTRL_CNT_W      = 4;
    localparam int unsigned CTRL_CNT_MAX    = 15;
    localparam int unsigned LAUNCH_CTRL_MIN = 4;
    localparam int unsigned PKT_CNT_W       = 5;

    typedef enum logic [1:0] {
        PT_CONTROL = 2'b00,
        PT_ISLAND  = 2'b01,
        PT_VIDEO   = 2'b10
    } period_t;

    typedef enum logic [2:0] {
        ST_CTRL,
        ST_DI_PRE,
        ST_DI_GB_LEAD,
        ST_DI_DATA,
        ST_DI_GB_TRAIL,
        ST_VID_PRE,
        ST_VID_GB,
        ST_VIDEO
    } state_t;

    // Encoder-facing control bundle; ctl is {CTL3,CTL2,CTL1,CTL0}
    typedef struct packed {
        period_t    period;
        logic       guard_band;
        logic [3:0] ctl;
    } enc_ctrl_t;

    function automatic enc_ctrl_t state_encoding(input state_t s);
        enc_ctrl_t e;
        e.period     = PT_CONTROL;
        e.guard_band = 1'b0;
        e.ctl        = 4'b0000;
        case (s)
            ST_DI_PRE:                    e.ctl = 4'b0101;
            ST_VID_PRE:                   e.ctl = 4'b0001;
            ST_DI_GB_LEAD, ST_DI_GB_TRAIL: begin
                e.period     = PT_ISLAND;
                e.guard_band = 1'b1;
            end
            ST_DI_DATA:                   e.period = PT_ISLAND;
            ST_VID_GB: begin
                e.period     = PT_VIDEO;
                e.guard_band = 1'b1;
            end
            ST_VIDEO:                     e.period = PT_VIDEO;
            default:                      e.period = PT_CONTROL;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter timing preamble and guard-band durations.
// Load with (length - 1); done is high on the final cycle of the period.
module period_timer
    import hdmi_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_done_c
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TIMER_W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Schedules HDMI control, data-island and video periods one cycle behind the
// timing generator, launching islands only when the blanking budget allows it.
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int unsigned MAX_PACKETS = 18
) (
    input  logic               tmds_clk,
    input  logic               n_rst,
    input  logic               de,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [BLANK_W-1:0] blank_remaining,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    output logic [1:0]         period_type,
    output logic               guard_band,
    output logic [1:0]         ctl_ch0,
    output logic [1:0]         ctl_ch1,
    output logic [1:0]         ctl_ch2,
    output logic [IDX_W-1:0]   pkt_bit_idx,
    output logic               protocol_err
);

    state_t                r_state, w_state_next;
    logic [CTRL_CNT_W-1:0] r_ctrl_cnt, w_ctrl_cnt_next;
    logic [PKT_CNT_W-1:0]  r_pkt_cnt, w_pkt_cnt_next;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_next;
    logic                  w_timer_load, w_timer_done;
    logic [TIMER_W-1:0]    w_timer_val;
    logic                  w_proto_err, w_launch, w_continue, w_de_fault, w_last_bit;
    enc_ctrl_t             w_enc;
    logic                  w_pkt_ready;

    period_timer u_timer (
        .i_clk      (tmds_clk),
        .i_rst_n    (n_rst),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_done_c   (w_timer_done)
    );

    assign w_launch   = pkt_valid && (r_ctrl_cnt >= CTRL_CNT_W'(LAUNCH_CTRL_MIN))
                        && (blank_remaining >= BLANK_W'(ISLAND_MARGIN));
    assign w_continue = pkt_valid && (r_pkt_cnt < PKT_CNT_W'(MAX_PACKETS))
                        && (blank_remaining >= BLANK_W'(CONTINUE_MARGIN));
    assign w_last_bit = (r_bit_idx == IDX_W'(PACKET_LEN - 1));
    // Video arriving outside a video preamble is a timing-generator fault
    assign w_de_fault = de && (r_state inside {ST_CTRL, ST_DI_PRE, ST_DI_GB_LEAD,
                                               ST_DI_DATA, ST_DI_GB_TRAIL});

    always_ff @(posedge tmds_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_CTRL;
            r_ctrl_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ctrl_cnt <= w_ctrl_cnt_next;
            r_pkt_cnt  <= w_pkt_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_timer_load    = 1'b0;
        w_timer_val     = '0;
        w_proto_err     = 1'b0;
        w_ctrl_cnt_next = '0;
        w_pkt_cnt_next  = '0;
        w_bit_idx_next  = '0;

        if (w_de_fault) begin
            w_state_next = ST_VIDEO;
            w_proto_err  = 1'b1;
        end else begin
            case (r_state)
                ST_CTRL: begin
                    if (blank_remaining == BLANK_W'(VIDEO_TRIGGER)) begin
                        w_state_next = ST_VID_PRE;
                        w_timer_load = 1'b1;
                        w_timer_val  = TIMER_W'(PREAMBLE_LEN - 1);
                    end else if (w_launch) begin
                        w_state_next = ST_DI_PRE;
                        w_timer_load = 1'b1;
                        w_timer_val  = TIMER_W'(PREAMBLE_LEN - 1);
                    end
                end
                ST_DI_PRE: if (w_timer_done) begin
                    w_state_next = ST_DI_GB_LEAD;
                    w_timer_load = 1'b1;
                    w_timer_val  = TIMER_W'(GUARD_LEN - 1);
                end
                ST_DI_GB_LEAD: if (w_timer_done) w_state_next = ST_DI_DATA;
                ST_DI_DATA: if (w_last_bit && !w_continue) begin
                    w_state_next = ST_DI_GB_TRAIL;
                    w_timer_load = 1'b1;
                    w_timer_val  = TIMER_W'(GUARD_LEN - 1);
                end
                ST_DI_GB_TRAIL: if (w_timer_done) w_state_next = ST_CTRL;
                ST_VID_PRE: if (w_timer_done) begin
                    w_state_next = ST_VID_GB;
                    w_timer_load = 1'b1;
                    w_timer_val  = TIMER_W'(GUARD_LEN - 1);
                end
                ST_VID_GB: if (w_timer_done) w_state_next = ST_VIDEO;
                ST_VIDEO: if (!de) w_state_next = ST_CTRL;
                default: w_state_next = ST_CTRL;
            endcase
        end

        // Control-cycle counter saturates and restarts on every CTRL entry
        if ((r_state == ST_CTRL) && (w_state_next == ST_CTRL)) begin
            w_ctrl_cnt_next = (r_ctrl_cnt == CTRL_CNT_W'(CTRL_CNT_MAX))
                              ? r_ctrl_cnt : r_ctrl_cnt + CTRL_CNT_W'(1);
        end

        if (w_state_next == ST_DI_DATA) begin
            if (r_state == ST_DI_DATA) begin
                w_bit_idx_next = r_bit_idx + IDX_W'(1);
                w_pkt_cnt_next = (w_bit_idx_next == '0) ? r_pkt_cnt + PKT_CNT_W'(1) : r_pkt_cnt;
            end else begin
                w_pkt_cnt_next = PKT_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_enc       = state_encoding(w_state_next);
        w_pkt_ready = (w_state_next == ST_DI_DATA) && (w_bit_idx_next == '0);
    end

    always_ff @(posedge tmds_clk or negedge n_rst) begin
        if (!n_rst) begin
            period_type  <= PT_CONTROL;
            guard_band   <= 1'b0;
            ctl_ch0      <= 2'b00;
            ctl_ch1      <= 2'b00;
            ctl_ch2      <= 2'b00;
            pkt_ready    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            period_type  <= w_enc.period;
            guard_band   <= w_enc.guard_band;
            ctl_ch0      <= {vsync, hsync};
            ctl_ch1      <= w_enc.ctl[1:0];
            ctl_ch2      <= w_enc.ctl[3:2];
            pkt_ready    <= w_pkt_ready;
            protocol_err <= w_proto_err;
        end
    end

    assign pkt_bit_idx = r_bit_idx;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench: a plan-queue model of the period schedule predicts every
// output cycle; a monitor compares the DUT one cycle after each stimulus.
module tb_hdmi_period_scheduler;

    localparam int MAXP = 18;
    localparam int K_CTRL = 0;
    localparam int K_ISL  = 1;
    localparam int K_VPRE = 2;
    localparam int K_VID  = 3;

    logic        tmds_clk;
    logic        n_rst;
    logic        de, hsync, vsync, pkt_valid;
    logic [11:0] blank_remaining;
    logic        pkt_ready, guard_band, protocol_err;
    logic [1:0]  period_type, ctl_ch0, ctl_ch1, ctl_ch2;
    logic [4:0]  pkt_bit_idx;

    hdmi_period_scheduler #(.MAX_PACKETS(MAXP)) dut (
        .tmds_clk        (tmds_clk),
        .n_rst           (n_rst),
        .de              (de),
        .hsync           (hsync),
        .vsync           (vsync),
        .blank_remaining (blank_remaining),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .period_type     (period_type),
        .guard_band      (guard_band),
        .ctl_ch0         (ctl_ch0),
        .ctl_ch1         (ctl_ch1),
        .ctl_ch2         (ctl_ch2),
        .pkt_bit_idx     (pkt_bit_idx),
        .protocol_err    (protocol_err)
    );

    typedef struct packed {
        logic [1:0] period;
        logic       gb;
        logic [3:0] ctl;
        logic [1:0] ch0;
        logic [4:0] idx;
        logic       rdy;
        logic       err;
    } obs_t;

    typedef struct {
        int   kind;
        obs_t o;
    } ent_t;

    obs_t sb_q[$];
    ent_t plan[$];
    ent_t cur;
    int   ctrl_before;
    int   pkts;
    bit   one_seen;
    bit   rst_pending;
    int   n_checks = 0;
    int   n_pass   = 0;

    initial begin
        tmds_clk = 1'b0;
        forever #5 tmds_clk = ~tmds_clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    endtask

    function automatic obs_t dut_obs();
        return {period_type, guard_band, ctl_ch2, ctl_ch1, ctl_ch0, pkt_bit_idx, pkt_ready, protocol_err};
    endfunction

    function automatic ent_t mk(input int kind, input logic [1:0] per, input logic gb,
                                input logic [3:0] ctl, input int idx, input logic rdy);
        ent_t e;
        e.kind     = kind;
        e.o.period = per;
        e.o.gb     = gb;
        e.o.ctl    = ctl;
        e.o.ch0    = 2'b00;
        e.o.idx    = 5'(idx);
        e.o.rdy    = rdy;
        e.o.err    = 1'b0;
        return e;
    endfunction

    function automatic void model_reset();
        plan.delete();
        cur         = mk(K_CTRL, 2'b00, 1'b0, 4'b0000, 0, 1'b0);
        ctrl_before = 0;
        pkts        = 0;
    endfunction

    function automatic void push_packet();
        for (int i = 0; i < 32; i++) plan.push_back(mk(K_ISL, 2'b01, 1'b0, 4'b0000, i, i == 0));
    endfunction

    // One clock of the schedule: decide at plan boundaries, otherwise follow the plan
    function automatic obs_t model_step(input logic de_i, input logic hs_i, input logic vs_i,
                                        input int br, input logic pv);
        ent_t nx;
        bit   last_bit;
        last_bit = (cur.kind == K_ISL) && (cur.o.period == 2'b01) && !cur.o.gb && (cur.o.idx == 5'd31);
        if (de_i && (cur.kind == K_CTRL || cur.kind == K_ISL)) begin
            plan.delete();
            nx = mk(K_VID, 2'b10, 1'b0, 4'b0000, 0, 1'b0);
            nx.o.err = 1'b1;
        end else begin
            if (plan.size() == 0) begin
                if (cur.kind == K_CTRL) begin
                    if (br == 10) begin
                        for (int i = 0; i < 8; i++) plan.push_back(mk(K_VPRE, 2'b00, 1'b0, 4'b0001, 0, 1'b0));
                        for (int i = 0; i < 2; i++) plan.push_back(mk(K_VPRE, 2'b10, 1'b1, 4'b0000, 0, 1'b0));
                        plan.push_back(mk(K_VID, 2'b10, 1'b0, 4'b0000, 0, 1'b0));
                    end else if (pv && ctrl_before >= 4 && br >= 58) begin
                        pkts = 0;
                        for (int i = 0; i < 8; i++) plan.push_back(mk(K_ISL, 2'b00, 1'b0, 4'b0101, 0, 1'b0));
                        for (int i = 0; i < 2; i++) plan.push_back(mk(K_ISL, 2'b01, 1'b1, 4'b0000, 0, 1'b0));
                        push_packet();
                    end
                end else if (last_bit) begin
                    if (pv && pkts < MAXP && br >= 48) push_packet();
                    else for (int i = 0; i < 2; i++) plan.push_back(mk(K_ISL, 2'b01, 1'b1, 4'b0000, 0, 1'b0));
                end else if (cur.kind == K_VID && de_i) begin
                    plan.push_back(mk(K_VID, 2'b10, 1'b0, 4'b0000, 0, 1'b0));
                end
            end
            if (plan.size() > 0) nx = plan.pop_front();
            else nx = mk(K_CTRL, 2'b00, 1'b0, 4'b0000, 0, 1'b0);
        end
        if (nx.kind == K_CTRL) ctrl_before = (cur.kind == K_CTRL) ? ctrl_before + 1 : 0;
        if (nx.o.rdy) begin
            pkts++;
            one_seen = 1'b1;
        end
        nx.o.ch0 = {vs_i, hs_i};
        cur = nx;
        return nx.o;
    endfunction

    task automatic mid_reset();
        #2;
        n_rst = 1'b0;
        sb_q.delete();
        #1;
        check("async_reset_outputs", dut_obs(), 16'h0000);
        @(negedge tmds_clk);
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic drive(input logic de_i, input int br, input logic pv);
        @(negedge tmds_clk);
        if (rst_pending && cur.kind == K_ISL && cur.o.period == 2'b01 && !cur.o.gb && cur.o.idx == 5'd15) begin
            rst_pending = 1'b0;
            mid_reset();
        end
        de              = de_i;
        blank_remaining = 12'(br);
        pkt_valid       = pv;
        hsync           = 1'($urandom_range(0, 1));
        vsync           = 1'($urandom_range(0, 1));
        sb_q.push_back(model_step(de_i, hsync, vsync, br, pv));
    endtask

    function automatic logic pv_for(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return !one_seen;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Blanking of 'blank' cycles (cut short when br hits 'cut'), then 'active' video cycles
    task automatic run_line(input int blank, input int active, input int cut, input int mode);
        one_seen = 1'b0;
        for (int j = 0; j < blank; j++) begin
            if (cut > 0 && (blank - j) == cut) break;
            drive(1'b0, blank - j, pv_for(mode));
        end
        for (int i = 0; i < active; i++) drive(1'b1, int'($urandom_range(0, 4095)), pv_for(mode));
    endtask

    initial begin
        forever begin
            @(posedge tmds_clk);
            #2;
            if (n_rst && sb_q.size() > 0) check("sched_out", dut_obs(), sb_q.pop_front());
        end
    end

    initial begin
        n_rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        pkt_valid = 1'b0; blank_remaining = 12'd0; rst_pending = 1'b0; one_seen = 1'b0;
        model_reset();
        #3;
        n_rst = 1'b0;
        repeat (2) @(posedge tmds_clk);
        #1;
        check("reset_outputs", dut_obs(), 16'h0000);
        @(negedge tmds_clk);
        n_rst = 1'b1;

        run_line(200, 20, 0, 0);
        run_line(100, 15, 0, 2);
        run_line(2000, 15, 0, 1);
        run_line(57, 15, 0, 1);
        run_line(100, 15, 30, 1);
        rst_pending = 1'b1;
        run_line(300, 15, 0, 1);
        check("reset_fired", 16'(rst_pending), 16'd0);

        for (int n = 0; n < 25; n++) begin
            int b, a, c;
            b = int'($urandom_range(1, 450));
            a = int'($urandom_range(1, 40));
            c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : 0;
            run_line(b, a, c, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge tmds_clk);
        check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
